// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder cell stepped over WIDTH cycles, with
// valid/ready handshakes on the operand and result sides.
//
// state | meaning
// IDLE  | waiting for operands (in_ready high); last result still on outputs
// RUN   | one bit of a + b + c processed per cycle, LSB first
// DONE  | result presented (out_valid) until the consumer takes it
module serial_adder_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH);
   localparam int SW = WIDTH - 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [SW-1:0]    sum_sh_q, sum_sh_d;
   logic             c_q, c_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;
   logic             bit_s, c_nxt;

   always_comb begin
      state_d  = state_q;
      a_sh_d   = a_sh_q;
      b_sh_d   = b_sh_q;
      sum_sh_d = sum_sh_q;
      c_d      = c_q;
      cnt_d    = cnt_q;
      sum_d    = sum_q;
      cout_d   = cout_q;
      ovf_d    = ovf_q;
      bit_s    = a_sh_q[0] ^ b_sh_q[0] ^ c_q;
      c_nxt    = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & c_q) | (b_sh_q[0] & c_q);

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_sh_d  = a;
               b_sh_d  = b;
               c_d     = cin;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
            b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
            sum_sh_d = SW'({bit_s, sum_sh_q} >> 1);
            c_d      = c_nxt;
            if (cnt_q == LAST_BIT) begin
               // c_q is the carry into the MSB here, c_nxt the carry out of it
               ovf_d   = c_q ^ c_nxt;
               cout_d  = c_nxt;
               sum_d   = {bit_s, sum_sh_q};
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         a_sh_q   <= '0;
         b_sh_q   <= '0;
         sum_sh_q <= '0;
         c_q      <= 1'b0;
         cnt_q    <= '0;
         sum_q    <= '0;
         cout_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_sh_q   <= a_sh_d;
         b_sh_q   <= b_sh_d;
         sum_sh_q <= sum_sh_d;
         c_q      <= c_d;
         cnt_q    <= cnt_d;
         sum_q    <= sum_d;
         cout_q   <= cout_d;
         ovf_q    <= ovf_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign sum       = sum_q;
   assign cout      = cout_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed and back-to-back random checks of serial_adder_ctrl at WIDTH=8 and WIDTH=2.
module tb_serial_adder_ctrl;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic       in_valid8 = 0, out_ready8 = 0, cin8 = 0;
   logic [7:0] a8 = 0, b8 = 0;
   logic       in_ready8, out_valid8, cout8, ovf8, busy8;
   logic [7:0] sum8;

   logic       in_valid2 = 0, out_ready2 = 0, cin2 = 0;
   logic [1:0] a2 = 0, b2 = 0;
   logic       in_ready2, out_valid2, cout2, ovf2, busy2;
   logic [1:0] sum2;

   serial_adder_ctrl #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
      .a(a8), .b(b8), .cin(cin8), .out_valid(out_valid8), .out_ready(out_ready8),
      .sum(sum8), .cout(cout8), .ovf(ovf8), .busy(busy8));

   serial_adder_ctrl #(.WIDTH(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
      .a(a2), .b(b2), .cin(cin2), .out_valid(out_valid2), .out_ready(out_ready2),
      .sum(sum2), .cout(cout2), .ovf(ovf2), .busy(busy2));

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       cin;
      logic [7:0] s;
      logic       co;
      logic       ov;
   } vec_t;

   vec_t tbl[11];

   task automatic check_reset_outputs(input string tag);
      chk({tag, " in_ready"},  {31'd0, in_ready8},  32'd1);
      chk({tag, " out_valid"}, {31'd0, out_valid8}, 32'd0);
      chk({tag, " busy"},      {31'd0, busy8},      32'd0);
      chk({tag, " sum"},       {24'd0, sum8},       32'd0);
      chk({tag, " cout"},      {31'd0, cout8},      32'd0);
      chk({tag, " ovf"},       {31'd0, ovf8},       32'd0);
   endtask

   // Accept one operation, scramble the inputs, measure latency, check and release the result.
   task automatic run_op8(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                          input logic [7:0] es, input logic eco, input logic eov);
      int  edges;
      bit  rdy_seen;
      @(negedge clk);
      chk("in_ready before accept", {31'd0, in_ready8}, 32'd1);
      a8 = ta; b8 = tb; cin8 = tc; in_valid8 = 1'b1; out_ready8 = 1'b0;
      @(posedge clk); #1;
      in_valid8 = 1'b0; a8 = ~ta; b8 = ~tb; cin8 = ~tc;
      edges = 0; rdy_seen = 0;
      while (!out_valid8 && edges < 20) begin
         if (in_ready8 || !busy8) rdy_seen = 1;
         @(posedge clk); #1;
         edges++;
      end
      chk("latency edges", edges, 32'd8);
      chk("in_ready low while busy", {31'd0, rdy_seen}, 32'd0);
      chk("sum",  {24'd0, sum8},  {24'd0, es});
      chk("cout", {31'd0, cout8}, {31'd0, eco});
      chk("ovf",  {31'd0, ovf8},  {31'd0, eov});
      @(negedge clk); out_ready8 = 1'b1;
      @(posedge clk); #1; out_ready8 = 1'b0;
      chk("idle after handshake", {30'd0, in_ready8, out_valid8}, 32'd2);
   endtask

   task automatic b2b8(input int n_ops);
      int cyc = 0, last = -1, done = 0;
      logic [7:0] ea = 0, eb = 0;
      logic ec = 0;
      logic [8:0] full;
      in_valid8 = 1'b1; out_ready8 = 1'b1;
      while (done < n_ops && cyc < n_ops * 12) begin
         @(negedge clk); cyc++;
         if (out_valid8) begin
            full = {1'b0, ea} + {1'b0, eb} + {8'd0, ec};
            chk("b2b8 sum",  {24'd0, sum8},  {24'd0, full[7:0]});
            chk("b2b8 cout", {31'd0, cout8}, {31'd0, full[8]});
            chk("b2b8 ovf",  {31'd0, ovf8},  {31'd0, (ea[7] == eb[7]) && (full[7] != ea[7])});
            if (last >= 0) chk("b2b8 period", cyc - last, 32'd10);
            last = cyc; done++;
            if (done == n_ops) in_valid8 = 1'b0;
         end
         if (in_ready8 && in_valid8) begin
            ea = 8'($urandom); eb = 8'($urandom); ec = 1'($urandom);
            a8 = ea; b8 = eb; cin8 = ec;
         end
      end
      chk("b2b8 ops completed", done, n_ops);
      in_valid8 = 1'b0;
      @(posedge clk); #1; out_ready8 = 1'b0;
   endtask

   task automatic b2b2(input int n_ops);
      int cyc = 0, last = -1, done = 0;
      logic [1:0] ea = 0, eb = 0;
      logic ec = 0;
      logic [2:0] full;
      in_valid2 = 1'b1; out_ready2 = 1'b1;
      while (done < n_ops && cyc < n_ops * 6) begin
         @(negedge clk); cyc++;
         if (out_valid2) begin
            full = {1'b0, ea} + {1'b0, eb} + {2'd0, ec};
            chk("b2b2 sum",  {30'd0, sum2},  {30'd0, full[1:0]});
            chk("b2b2 cout", {31'd0, cout2}, {31'd0, full[2]});
            chk("b2b2 ovf",  {31'd0, ovf2},  {31'd0, (ea[1] == eb[1]) && (full[1] != ea[1])});
            if (last >= 0) chk("b2b2 period", cyc - last, 32'd4);
            last = cyc; done++;
            if (done == n_ops) in_valid2 = 1'b0;
         end
         if (in_ready2 && in_valid2) begin
            ea = 2'($urandom); eb = 2'($urandom); ec = 1'($urandom);
            a2 = ea; b2 = eb; cin2 = ec;
         end
      end
      chk("b2b2 ops completed", done, n_ops);
      in_valid2 = 1'b0;
      @(posedge clk); #1; out_ready2 = 1'b0;
   endtask

   initial begin
      tbl[0]  = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0};
      tbl[1]  = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
      tbl[2]  = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
      tbl[3]  = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
      tbl[4]  = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
      tbl[5]  = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
      tbl[6]  = '{8'h7F, 8'h7F, 1'b1, 8'hFF, 1'b0, 1'b1};
      tbl[7]  = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
      tbl[8]  = '{8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0, 1'b0};
      tbl[9]  = '{8'h80, 8'h7F, 1'b1, 8'h00, 1'b1, 1'b0};
      tbl[10] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0};

      #12;
      check_reset_outputs("in reset");
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
      check_reset_outputs("after reset");

      for (int i = 0; i < 11; i++)
         run_op8(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].s, tbl[i].co, tbl[i].ov);

      // Result held for 5 cycles while in_valid pulses with new operands.
      @(negedge clk);
      a8 = 8'h3C; b8 = 8'h0A; cin8 = 1'b1; in_valid8 = 1'b1;
      @(posedge clk); #1; in_valid8 = 1'b0;
      for (int i = 0; i < 30 && !out_valid8; i++) begin
         @(posedge clk); #1;
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("hold out_valid", {31'd0, out_valid8}, 32'd1);
         chk("hold sum", {24'd0, sum8}, 32'h47);
         a8 = 8'(i * 17); b8 = 8'hEE; in_valid8 = i[0];
      end
      @(negedge clk);
      chk("hold sum final", {24'd0, sum8}, 32'h47);
      in_valid8 = 1'b1; out_ready8 = 1'b1;
      @(posedge clk); #1;
      in_valid8 = 1'b0; out_ready8 = 1'b0;
      chk("no accept on handshake edge", {29'd0, in_ready8, out_valid8, busy8}, 32'd4);
      chk("sum kept in idle", {24'd0, sum8}, 32'h47);

      // Abort mid-RUN.
      @(negedge clk);
      a8 = 8'h55; b8 = 8'h11; cin8 = 1'b0; in_valid8 = 1'b1;
      @(posedge clk); #1; in_valid8 = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b0;
      #1 check_reset_outputs("abort");
      @(negedge clk); rst_n = 1'b1;
      run_op8(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);

      b2b8(1000);
      b2b2(1000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
